// File: rtl/adc_dly_align_ctrl.sv
// adc_dly_align_ctrl: sweeps every IODELAY tap of each ADC channel against the
// test pattern, then loads the centre of the widest passing window.
module adc_dly_align_ctrl #(
    parameter int          NCH         = 16,
    parameter int          NTAPS       = 32,
    parameter int          SETTLE      = 8,
    parameter int          NSAMP       = 16,
    parameter logic [11:0] PATTERN     = 12'hA5C,
    parameter int          MIN_EYE     = 4,
    parameter int          DEFAULT_TAP = 25
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [NCH*12-1:0] DIN,
    output logic [NCH*5-1:0]  TAP_OUT,
    output logic [NCH-1:0]    DLY_LD,
    output logic              BUSY,
    output logic              DONE,
    output logic [NCH-1:0]    FAIL
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = 5;
    localparam int LW = TW + 1;
    localparam int MX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
    localparam int KW = $clog2(MX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_CENTER,
        S_NEXT,
        S_FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] ch;
    logic [TW-1:0] tap;
    logic [KW-1:0] cnt;
    logic          err;
    logic [TW-1:0] run_start;
    logic [LW-1:0] run_len;
    logic [TW-1:0] best_start;
    logic [LW-1:0] best_len;
    logic [TW-1:0] taps [NCH];

    logic [11:0]    din_ch;
    logic [CW-1:0]  ch_nxt;
    logic [NCH-1:0] ld_cur;
    logic [NCH-1:0] ld_nxt;
    logic [TW-1:0]  cand_start;
    logic [LW-1:0]  cand_len;
    logic           last_tap;
    logic           close_run;
    logic [TW-1:0]  center_tap;

    for (genvar g = 0; g < NCH; g++) begin : g_tap
        assign TAP_OUT[TW*g +: TW] = taps[g];
    end

    always_comb begin
        din_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CW'(i) == ch) din_ch = DIN[12*i +: 12];
        end
    end

    assign ch_nxt = ch + CW'(1);
    assign ld_cur = NCH'(1) << ch;
    assign ld_nxt = NCH'(1) << ch_nxt;
    assign last_tap = (tap == TW'(NTAPS - 1));
    assign close_run = err || last_tap;
    // floor(len/2) never carries past 31 for a window inside 0..NTAPS-1
    assign center_tap = best_start + best_len[TW:1];

    always_comb begin
        cand_len = run_len;
        cand_start = run_start;
        if (!err) begin
            cand_len = run_len + LW'(1);
            if (run_len == '0) cand_start = tap;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            ch <= '0;
            tap <= '0;
            cnt <= '0;
            err <= 1'b0;
            run_start <= '0;
            run_len <= '0;
            best_start <= '0;
            best_len <= '0;
            DLY_LD <= '0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            FAIL <= '0;
            for (int i = 0; i < NCH; i++) taps[i] <= TW'(DEFAULT_TAP);
        end else begin
            DLY_LD <= '0;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        ch <= '0;
                        tap <= '0;
                        err <= 1'b0;
                        run_len <= '0;
                        best_len <= '0;
                        best_start <= '0;
                        DONE <= 1'b0;
                        FAIL <= '0;
                        BUSY <= 1'b1;
                        taps[0] <= '0;
                        DLY_LD <= NCH'(1);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == KW'(SETTLE - 1)) begin
                        cnt <= '0;
                        err <= 1'b0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + KW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (din_ch != PATTERN) err <= 1'b1;
                    if (cnt == KW'(NSAMP - 1)) state <= S_EVAL;
                    else cnt <= cnt + KW'(1);
                end
                S_EVAL: begin
                    // strict compare keeps the earlier window on a tie
                    if (close_run) begin
                        run_len <= '0;
                        if (cand_len > best_len) begin
                            best_len <= cand_len;
                            best_start <= cand_start;
                        end
                    end else begin
                        run_len <= cand_len;
                        run_start <= cand_start;
                    end
                    if (last_tap) begin
                        state <= S_CENTER;
                    end else begin
                        tap <= tap + TW'(1);
                        taps[ch] <= tap + TW'(1);
                        DLY_LD <= ld_cur;
                        state <= S_LOAD;
                    end
                end
                S_CENTER: begin
                    if (best_len < LW'(MIN_EYE)) begin
                        taps[ch] <= TW'(DEFAULT_TAP);
                        FAIL[ch] <= 1'b1;
                    end else begin
                        taps[ch] <= center_tap;
                    end
                    DLY_LD <= ld_cur;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    err <= 1'b0;
                    run_len <= '0;
                    run_start <= '0;
                    best_len <= '0;
                    best_start <= '0;
                    tap <= '0;
                    if (ch == CW'(NCH - 1)) begin
                        state <= S_FIN;
                    end else begin
                        ch <= ch_nxt;
                        taps[ch_nxt] <= '0;
                        DLY_LD <= ld_nxt;
                        state <= S_LOAD;
                    end
                end
                S_FIN: begin
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dly_align_ctrl.sv
// tb_adc_dly_align_ctrl: emulates per-channel IODELAY eyes on DIN and checks
// the chosen taps against a window-search reference model.
module tb_adc_dly_align_ctrl;

    localparam int          NCH      = 16;
    localparam logic [11:0] PAT      = 12'hA5C;
    localparam int          DONE_CYC = 13345;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NCH*12-1:0]   din;
    logic [NCH*5-1:0]    tap_out;
    logic [NCH-1:0]      dly_ld;
    logic                busy;
    logic                done;
    logic [NCH-1:0]      fail_vec;

    always #5 clk = ~clk;

    adc_dly_align_ctrl dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .DIN     (din),
        .TAP_OUT (tap_out),
        .DLY_LD  (dly_ld),
        .BUSY    (busy),
        .DONE    (done),
        .FAIL    (fail_vec)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    bit [31:0] pass_map [NCH];
    int emu_tap [NCH];
    int since [NCH];
    int bad_at [NCH];
    int ld_cnt [NCH];
    int viol = 0;
    int glitch_ch = -1;
    int glitch_tap = -1;

    // IODELAY/ADC emulation: the word is clean only if the loaded tap is in
    // the eye; garbage while the delay line settles
    always @(negedge clk) begin
        logic [11:0] w;
        bit ok;
        bit bad;
        if (!$onehot0(dly_ld)) viol++;
        for (int i = 0; i < NCH; i++) begin
            if (dly_ld[i]) begin
                emu_tap[i] = int'(tap_out[5*i +: 5]);
                since[i] = 0;
                bad_at[i] = int'($urandom_range(9, 24));
                ld_cnt[i]++;
            end else if (since[i] < 1000) begin
                since[i]++;
            end
            ok = pass_map[i][emu_tap[i]];
            if (since[i] >= 9 && since[i] <= 24) begin
                if (since[i] == bad_at[i])
                    bad = !ok || (i == glitch_ch && emu_tap[i] == glitch_tap);
                else
                    bad = !ok && ($urandom_range(0, 1) == 1);
                w = bad ? (PAT ^ 12'($urandom_range(1, 4095))) : PAT;
            end else begin
                w = 12'($urandom);
            end
            din[12*i +: 12] = w;
        end
    end

    function automatic bit [31:0] win(input int lo, input int hi);
        bit [31:0] m = '0;
        for (int k = lo; k <= hi && k < 32; k++) m[k] = 1'b1;
        return m;
    endfunction

    // widest run of ones, earliest on a tie, centre = start + floor(width/2)
    task automatic ref_cal(input bit [31:0] m, output int t, output bit f);
        int bs = 0;
        int bw = 0;
        for (int s = 0; s < 32; s++) begin
            if (m[s] && (s == 0 || !m[s-1])) begin
                int w = 0;
                while (s + w < 32 && m[s+w]) w++;
                if (w > bw) begin
                    bw = w;
                    bs = s;
                end
            end
        end
        f = (bw < 4);
        t = f ? 25 : bs + bw / 2;
    endtask

    function automatic int total_ld();
        int s = 0;
        for (int i = 0; i < NCH; i++) s += ld_cnt[i];
        return s;
    endfunction

    function automatic int taps_not(input int v);
        int c = 0;
        for (int i = 0; i < NCH; i++)
            if (int'(tap_out[5*i +: 5]) != v) c++;
        return c;
    endfunction

    task automatic rand_maps();
        for (int i = 0; i < NCH; i++) begin
            int lo = int'($urandom_range(0, 31));
            int hi = lo + int'($urandom_range(0, 12));
            unique case (i % 3)
                0: pass_map[i] = $urandom;
                1: pass_map[i] = win(lo, hi);
                default: pass_map[i] = win(lo, hi) | win(hi + 3, hi + 9);
            endcase
        end
    endtask

    task automatic run_cal(input int repulse_at, input int abort_at);
        int n = 0;
        int busy_low = 0;
        int ld0;
        int t;
        bit f;
        bit [31:0] eff;
        logic [NCH-1:0] exp_fail;
        for (int i = 0; i < NCH; i++) ld_cnt[i] = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_on_start", busy, 1);
        check("done_clr_start", done, 0);
        while (!done && n < 20000 && !(abort_at > 0 && n >= abort_at)) begin
            @(negedge clk);
            start = (n == repulse_at);
            rst = (abort_at > 0 && n == abort_at - 1);
            @(posedge clk);
            #1;
            n++;
            if (!rst && !busy && !done) busy_low++;
        end
        start = 1'b0;
        check("busy_gaps", busy_low, 0);
        if (abort_at > 0) begin
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_fail", fail_vec, 0);
            check("abort_ld", dly_ld, 0);
            check("abort_taps", taps_not(25), 0);
            @(negedge clk);
            rst = 1'b0;
            ld0 = total_ld();
            repeat (40) @(negedge clk);
            check("abort_no_load", total_ld() - ld0, 0);
            check("abort_idle", busy, 0);
            return;
        end
        check("done_cycle", n, DONE_CYC);
        check("busy_off", busy, 0);
        exp_fail = '0;
        for (int i = 0; i < NCH; i++) begin
            eff = pass_map[i];
            if (i == glitch_ch) eff[glitch_tap] = 1'b0;
            ref_cal(eff, t, f);
            exp_fail[i] = f;
            check($sformatf("tap_ch%0d", i), tap_out[5*i +: 5], t);
            check($sformatf("loads_ch%0d", i), ld_cnt[i], 33);
        end
        check("fail_vec", fail_vec, exp_fail);
        repeat (5) @(negedge clk);
        check("done_level", done, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        din = '0;
        for (int i = 0; i < NCH; i++) begin
            pass_map[i] = '0;
            emu_tap[i] = 25;
            since[i] = 1000;
            bad_at[i] = 9;
            ld_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_taps", taps_not(25), 0);
        check("rst_ld", dly_ld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail_vec, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NCH; i++) pass_map[i] = win(10, 20);
        run_cal(3000, 0);
        check("eye10_20_all15", taps_not(15), 0);

        rand_maps();
        pass_map[0] = win(10, 20);
        pass_map[1] = 32'hFFFF_FFFF;
        pass_map[3] = win(2, 5) | win(12, 15);
        pass_map[5] = '0;
        pass_map[7] = win(28, 31);
        pass_map[9] = win(6, 8);
        glitch_ch = 0;
        glitch_tap = 14;
        run_cal(-1, 0);
        check("glitch_ch0", tap_out[4:0], 18);
        check("allpass_ch1", tap_out[9:5], 16);
        check("tie_ch3", tap_out[19:15], 4);
        check("edge_ch7", tap_out[39:35], 30);
        check("nomatch_ch5", tap_out[29:25], 25);
        check("narrow_ch9", tap_out[49:45], 25);
        check("fail_5_9", fail_vec & 16'h0220, 16'h0220);
        glitch_ch = -1;
        glitch_tap = -1;

        rand_maps();
        run_cal(2500, 5000);
        rand_maps();
        pass_map[2] = win(0, 3);
        run_cal(-1, 0);
        check("dly_ld_onehot", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
